// File: rtl/sal_rd_resp_merger_pkg.sv
// sal_rd_resp_merger_pkg: shared DDR/AXI widths and types for the read-response path.
package sal_rd_resp_merger_pkg;
    localparam int DRAM_BK_CNT    = 4;
    localparam int AXI_DATA_WIDTH = 64;
    localparam int AXI_ID_W       = 4;
    localparam int SEQ_W          = 4;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    typedef logic [AXI_ID_W-1:0] axi_id_t;
    typedef logic [SEQ_W-1:0]    seq_num_t;
endpackage

// File: rtl/sal_rd_resp_merger_r_out_reg.sv
// sal_rd_resp_merger_r_out_reg: single-entry valid/ready register driving the AXI R channel.
module sal_rd_resp_merger_r_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    logic         valid_q;
    logic [W-1:0] data_q;
    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    always_ff @(posedge clk) begin
        if (!rst_n)
            valid_q <= 1'b0;
        else if (in_ready_o)
            valid_q <= in_valid_i;
    end
    always_ff @(posedge clk) begin
        if (in_valid_i && in_ready_o)
            data_q <= in_data_i;
    end
endmodule

// File: rtl/sal_rd_resp_merger.sv
// sal_rd_resp_merger: merges per-bank read bursts onto AXI R in read sequence-number order.
module sal_rd_resp_merger
    import sal_rd_resp_merger_pkg::*;
#(
    parameter int BK_CNT = DRAM_BK_CNT,
    parameter int DATA_W = AXI_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [BK_CNT-1:0]          bk_rvalid_i,
    output logic [BK_CNT-1:0]          bk_rready_o,
    input  logic [BK_CNT*AXI_ID_W-1:0] bk_rid_i,
    input  logic [BK_CNT*DATA_W-1:0]   bk_rdata_i,
    input  logic [BK_CNT-1:0]          bk_rlast_i,
    input  logic [BK_CNT*SEQ_W-1:0]    bk_seq_num_i,
    output logic                       r_valid_o,
    input  logic                       r_ready_i,
    output logic [AXI_ID_W-1:0]        r_id_o,
    output logic [DATA_W-1:0]          r_data_o,
    output logic [1:0]                 r_resp_o,
    output logic                       r_last_o
);
    localparam int BK_W = BK_CNT > 1 ? $clog2(BK_CNT) : 1;
    localparam int PW   = AXI_ID_W + DATA_W + 1;
    typedef enum logic {ST_IDLE, ST_BURST} state_t;
    state_t          state_q;
    seq_num_t        expected_seq_q;
    logic [BK_W-1:0] lock_bk_q;
    logic [BK_CNT-1:0] elig;
    logic [BK_W-1:0]   sel;
    logic              any, dup, out_ready, take, sel_last;
    always_comb begin
        elig = '0;
        sel  = '0;
        any  = 1'b0;
        for (int i = 0; i < BK_CNT; i++)
            elig[i] = bk_rvalid_i[i] && (state_q == ST_BURST ? lock_bk_q == BK_W'(i)
                                         : bk_seq_num_i[i*SEQ_W +: SEQ_W] == expected_seq_q);
        // Downward scan leaves the lowest eligible index selected.
        for (int i = BK_CNT - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel = BK_W'(i);
                any = 1'b1;
            end
        end
    end
    assign take        = any && out_ready && rst_n;
    assign bk_rready_o = take ? BK_CNT'(1) << sel : '0;
    assign sel_last    = bk_rlast_i[sel];
    assign r_resp_o    = RESP_OKAY;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            expected_seq_q <= '0;
            lock_bk_q      <= '0;
        end else if (take) begin
            if (sel_last) begin
                state_q        <= ST_IDLE;
                expected_seq_q <= expected_seq_q + 1'b1;
            end else begin
                state_q   <= ST_BURST;
                lock_bk_q <= sel;
            end
        end
    end
    sal_rd_resp_merger_r_out_reg #(.W(PW)) u_out (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (take),
        .in_ready_o (out_ready),
        .in_data_i  ({bk_rid_i[sel*AXI_ID_W +: AXI_ID_W], bk_rdata_i[sel*DATA_W +: DATA_W], sel_last}),
        .out_valid_o(r_valid_o),
        .out_ready_i(r_ready_i),
        .out_data_o ({r_id_o, r_data_o, r_last_o})
    );
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < BK_CNT; i++)
            for (int j = i + 1; j < BK_CNT; j++)
                if (bk_rvalid_i[i] && bk_rvalid_i[j] &&
                    bk_seq_num_i[i*SEQ_W +: SEQ_W] == bk_seq_num_i[j*SEQ_W +: SEQ_W])
                    dup = 1'b1;
    end
    a_unique_seq: assert property (@(posedge clk) disable iff (!rst_n) !dup)
        else $error("two banks present the same seq_num");
endmodule

// File: tb/tb_sal_rd_resp_merger.sv
// tb_sal_rd_resp_merger: directed and random checks of sequence-ordered read merging.
module tb_sal_rd_resp_merger;
    import sal_rd_resp_merger_pkg::*;
    localparam int BK = 4, DW = 64, IW = AXI_ID_W, SW = SEQ_W, MAXB = 4, NBURST = 1000;
    typedef struct packed {logic [IW-1:0] id; logic [DW-1:0] data; logic last;} beat_t;

    logic clk, rst_n, r_ready, r_valid, r_last;
    logic [BK-1:0] bk_rvalid, bk_rready, bk_rlast;
    logic [BK*IW-1:0] bk_rid;
    logic [BK*DW-1:0] bk_rdata;
    logic [BK*SW-1:0] bk_seq;
    logic [IW-1:0] r_id;
    logic [DW-1:0] r_data;
    logic [1:0] r_resp;

    sal_rd_resp_merger #(.BK_CNT(BK), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .bk_rvalid_i(bk_rvalid), .bk_rready_o(bk_rready), .bk_rid_i(bk_rid),
        .bk_rdata_i(bk_rdata), .bk_rlast_i(bk_rlast), .bk_seq_num_i(bk_seq),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
        .r_resp_o(r_resp), .r_last_o(r_last)
    );

    beat_t exp_q[$];
    int oc[$];
    int checks = 0, errors = 0, cyc = 0, out_cnt = 0;
    bit act[BK], hold[BK];
    int nb[BK], bi[BK], sq[BK];
    logic [IW-1:0] bid[BK];
    logic [DW-1:0] bdat[BK][MAXB];
    bit auto_mode = 0;
    int next_seq = 0, issued = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(string name, logic [127:0] got, logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endtask

    // A burst is queued in the scoreboard in the order it is issued, which is seq order.
    task automatic load(int b, int s, int n, bit h);
        beat_t e;
        act[b] = 1; hold[b] = h; nb[b] = n; bi[b] = 0; sq[b] = s;
        bid[b] = IW'($urandom);
        for (int k = 0; k < n; k++) begin
            bdat[b][k] = {$urandom, $urandom};
            e.id = bid[b]; e.data = bdat[b][k]; e.last = (k == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(string name, int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    // Bank drivers: present the current beat, advance when the merger accepted it.
    initial begin
        logic [BK-1:0] fire;
        forever begin
            @(negedge clk);
            fire = bk_rvalid & bk_rready;
            @(posedge clk);
            #1;
            for (int b = 0; b < BK; b++)
                if (fire[b] && act[b]) begin
                    bi[b]++;
                    if (bi[b] == nb[b]) act[b] = 0;
                end
            if (auto_mode) begin
                for (int b = 0; b < BK; b++)
                    if (!act[b] && issued < NBURST && $urandom_range(2) == 0) begin
                        load(b, next_seq, $urandom_range(MAXB, 1), 0);
                        next_seq++;
                        issued++;
                    end
                r_ready = ($urandom_range(9) < 7);
            end
            for (int b = 0; b < BK; b++) begin
                bk_rvalid[b]          = act[b] && !hold[b];
                bk_rid[b*IW +: IW]    = bid[b];
                bk_rdata[b*DW +: DW]  = bdat[b][act[b] ? bi[b] : 0];
                bk_rlast[b]           = act[b] && (bi[b] == nb[b] - 1);
                bk_seq[b*SW +: SW]    = SW'(sq[b]);
            end
        end
    end

    // Monitor: pops the scoreboard on every R handshake and checks handshake rules.
    initial begin
        beat_t got, prev;
        bit stall = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("rst_bk_rready", bk_rready, 0);
                stall = 0;
                continue;
            end
            chk("bk_rready_onehot", $countones(bk_rready) <= 1, 1);
            got.id = r_id; got.data = r_data; got.last = r_last;
            if (stall) begin
                chk("stall_rvalid", r_valid, 1);
                chk("stall_hold", got, prev);
            end
            if (r_valid && !r_ready) chk("stall_bk_rready", bk_rready, 0);
            stall = r_valid && !r_ready;
            prev = got;
            if (r_valid && r_ready) begin
                out_cnt++;
                oc.push_back(cyc);
                if (oc.size() > 4) void'(oc.pop_front());
                chk("rresp", r_resp, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat got %0h expected none", got);
                end else chk("beat", got, exp_q.pop_front());
            end
        end
    end

    initial begin
        int c, n;
        rst_n = 0; r_ready = 1;
        bk_rvalid = '0; bk_rid = '0; bk_rdata = '0; bk_rlast = '0; bk_seq = '0;
        for (int b = 0; b < BK; b++) begin act[b] = 0; hold[b] = 0; nb[b] = 0; bi[b] = 0; sq[b] = 0; bid[b] = '0; end
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        chk("reset_rvalid", r_valid, 0);
        // Simultaneous bursts: seq0 on bank2 must precede seq1 on bank0, back to back.
        @(posedge clk);
        #2 load(2, 0, 2, 0); load(0, 1, 2, 0);
        wait_drain("t028_drain", 50);
        chk("t028_consecutive", oc[3] - oc[0], 3);
        // Out-of-order arrival: seq3 waits until seq2 shows up.
        load(3, 2, 2, 1); load(1, 3, 3, 0);
        repeat (20) begin
            @(negedge clk);
            chk("t029_bk1_rready", bk_rready[1], 0);
            chk("t029_rvalid", r_valid, 0);
        end
        @(posedge clk);
        #2 hold[3] = 0;
        wait_drain("t029_drain", 50);
        // Output backpressure mid-burst.
        load(0, 4, 4, 0);
        c = out_cnt; n = 0;
        while (out_cnt == c && n < 50) begin @(posedge clk); #2; n++; end
        chk("t030_first_beat", out_cnt > c, 1);
        r_ready = 0;
        @(posedge clk);
        @(posedge clk);
        #2 r_ready = 1;
        wait_drain("t030_drain", 50);
        // Reset after the second beat of a 4-beat burst.
        load(1, 5, 4, 0);
        c = out_cnt; n = 0;
        while (out_cnt < c + 2 && n < 50) begin @(posedge clk); #2; n++; end
        chk("t032_two_beats", out_cnt >= c + 2, 1);
        rst_n = 0;
        @(posedge clk);
        #2 rst_n = 1;
        for (int b = 0; b < BK; b++) act[b] = 0;
        exp_q.delete();
        @(negedge clk);
        chk("t032_rvalid", r_valid, 0);
        @(posedge clk);
        #2 load(2, 0, 3, 0);
        wait_drain("t032_seq0_drain", 50);
        // Random traffic; seq numbers wrap many times over the run.
        next_seq = 1; issued = 0; auto_mode = 1;
        n = 0;
        while ((issued < NBURST || exp_q.size() != 0) && n < 60000) begin @(posedge clk); n++; end
        chk("random_issued", issued, NBURST);
        chk("random_drain", exp_q.size(), 0);
        auto_mode = 0;
        #2 r_ready = 1;
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
